fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Fetch stage that consumes the next-PC value chosen by the PC-select mux (PCF_bar) and holds the architectural fetch PC (PCF).
- Generates PCPlus4F back to the mux.
- Runs a single-outstanding request/response handshake to instruction memory.
- Owns the IF/ID pipeline register (InstrD, PCD, PCPlus4D, ValidD), including a one-entry hold buffer, decode stall, flush and branch-redirect squash.

Parameters:
RESET_PC, 32'h0000_0000, PCF value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction written into InstrD on bubble/flush (addi x0,x0,0)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
PCF_bar  input  32  next PC from PC-select mux (PCPlus4F or PCTargetE)
PCSrcE  input  1  branch/jump redirect taken in Execute (same signal driving the mux)
StallD  input  1  hazard unit: hold IF/ID
FlushD  input  1  hazard unit: clear IF/ID
PCF  output  32  current fetch PC
PCPlus4F  output  32  PCF + 4, combinational, to mux
imem_req  output  1  instruction-memory request valid
imem_addr  output  32  request address, equals PCF
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response valid; at least 1 cycle after grant
imem_rdata  input  32  response instruction
InstrD  output  32  IF/ID instruction
PCD  output  32  IF/ID PC
PCPlus4D  output  32  IF/ID PC+4
ValidD  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst_n=0, async):
  - PCF=RESET_PC; state=REQ; squash=0.
  - InstrD=NOP_INSTR; PCD=0; PCPlus4D=0; ValidD=0.
  - Hold buffer cleared.
- PCPlus4F = PCF+4, modulo 2^32 (32'hFFFF_FFFC -> 0). imem_addr=PCF.
- PC update: every load of PCF takes {PCF_bar[31:2],2'b00}. Low bits are forced to zero.
- FSM state REQ:
  - imem_req=1.
  - gnt=1: go to WAIT.
  - PCSrcE=1 without gnt: PCF<=PCF_bar, stay in REQ.
  - PCSrcE=1 with gnt in the same cycle: PCF<=PCF_bar, go to WAIT with squash=1, because the old address was accepted.
- FSM state WAIT:
  - imem_req=0.
  - PCSrcE=1 without rvalid: PCF<=PCF_bar, squash<=1, stay in WAIT.
  - rvalid with squash=1: discard data, squash<=0, go to REQ. PCF is unchanged unless PCSrcE=1 this cycle.
  - rvalid with PCSrcE=1: discard data, PCF<=PCF_bar, go to REQ.
  - rvalid with StallD=0: load IF/ID with {imem_rdata, PCF, PCPlus4F}, ValidD<=1; PCF<=PCF_bar; go to REQ.
  - rvalid with StallD=1: capture {imem_rdata, PCF, PCPlus4F} into the hold buffer, go to HOLD. PCF is unchanged.
- FSM state HOLD:
  - imem_req=0.
  - PCSrcE=1: discard the buffer, PCF<=PCF_bar, go to REQ.
  - StallD=0: load IF/ID from the buffer, ValidD<=1, PCF<=PCF_bar, go to REQ.
  - Otherwise wait.
- IF/ID priority, evaluated per cycle:
  1. FlushD=1 or PCSrcE=1: InstrD<=NOP_INSTR, ValidD<=0, PCD/PCPlus4D<=0.
  2. StallD=1: hold all four registers.
  3. Load as defined above.
  4. Otherwise bubble: NOP_INSTR, ValidD=0.
- FlushD alone does not alter PCF, the FSM or squash.
- At most one request outstanding. No request is issued in WAIT or HOLD.
- Redirect latency: the target appears on PCF the cycle after PCSrcE. The first target request issues from REQ in that cycle, unless a squashed response is still pending.
- If reset deasserts mid-transaction, a stale imem_rvalid arriving in REQ is ignored.

Test Plan:
- Reset with RESET_PC=0x100, then release; memory grants immediately and returns 0xAAAA_0001 one cycle later:
  - PCF=0x100, imem_req=1.
  - Next: state WAIT.
  - Next: InstrD=0xAAAA_0001, PCD=0x100, PCPlus4D=0x104, ValidD=1, PCF=0x104.
- Straight-line stream with 1-cycle memory: PCF steps 0x100, 0x104, 0x108. ValidD alternates 1 with bubble cycles (NOP_INSTR, ValidD=0).
- StallD=1 for 3 cycles when rvalid arrives with 0x1234_5678 at PCF=0x200:
  - State HOLD, PCF stays 0x200, IF/ID unchanged.
  - On StallD=0: InstrD=0x1234_5678, PCD=0x200, PCF=0x204.
- PCSrcE=1 with PCF_bar=0x400 while in WAIT:
  - PCF=0x400, ValidD=0.
  - The returning response for the old PC is discarded.
  - The next request has imem_addr=0x400.
- PCSrcE=1 and imem_gnt=1 in the same cycle with PCF_bar=0x802: PCF=0x800 (low bits cleared), squash set, the following rvalid is discarded.
- FlushD=1 together with StallD=1 while ValidD=1: InstrD=0x0000_0013, ValidD=0, PCF unchanged.
- PCF=0xFFFF_FFFC: PCPlus4F=0x0000_0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: fetch PC, single-outstanding imem handshake and the
// IF/ID pipeline register with a one-entry hold buffer for decode stalls.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF_bar,
    input  logic        PCSrcE,
    input  logic        StallD,
    input  logic        FlushD,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pcf;
    logic [31:0] w_pcf_nxt;
    logic        r_squash;
    logic        w_squash_nxt;
    logic        w_hold_cap;
    logic        w_load_mem;
    logic        w_load_hold;
    logic [31:0] w_pc_target;
    logic [31:0] w_pcplus4;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_pc4;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc4_d;
    logic        r_valid_d;

    assign w_pc_target = {PCF_bar[31:2], 2'b00};
    assign w_pcplus4   = r_pcf + 32'd4;

    assign PCF       = r_pcf;
    assign PCPlus4F  = w_pcplus4;
    assign imem_addr = r_pcf;
    assign imem_req  = (r_state == ST_REQ);
    assign InstrD    = r_instr_d;
    assign PCD       = r_pc_d;
    assign PCPlus4D  = r_pc4_d;
    assign ValidD    = r_valid_d;

    // Fetch FSM: next state, next PC, squash flag and IF/ID load strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_pcf_nxt    = r_pcf;
        w_squash_nxt = r_squash;
        w_hold_cap   = 1'b0;
        w_load_mem   = 1'b0;
        w_load_hold  = 1'b0;
        case (r_state)
            ST_REQ: begin
                // A redirect granted in the same cycle leaves the old address in flight
                if (imem_gnt) begin
                    w_state_nxt  = ST_WAIT;
                    w_squash_nxt = PCSrcE;
                end else begin
                    w_state_nxt  = ST_REQ;
                end
                if (PCSrcE) begin
                    w_pcf_nxt = w_pc_target;
                end else begin
                    w_pcf_nxt = r_pcf;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (r_squash || PCSrcE) begin
                        w_squash_nxt = 1'b0;
                        w_state_nxt  = ST_REQ;
                        w_pcf_nxt    = PCSrcE ? w_pc_target : r_pcf;
                    end else if (!StallD) begin
                        w_load_mem  = 1'b1;
                        w_pcf_nxt   = w_pc_target;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_hold_cap  = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end else if (PCSrcE) begin
                    w_pcf_nxt    = w_pc_target;
                    w_squash_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (PCSrcE) begin
                    w_pcf_nxt   = w_pc_target;
                    w_state_nxt = ST_REQ;
                end else if (!StallD) begin
                    w_load_hold = 1'b1;
                    w_pcf_nxt   = w_pc_target;
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt  = ST_REQ;
                w_squash_nxt = 1'b0;
            end
        endcase
    end

    // Fetch state, PC and squash registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_REQ;
            r_pcf    <= RESET_PC;
            r_squash <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pcf    <= w_pcf_nxt;
            r_squash <= w_squash_nxt;
        end
    end

    // Hold buffer for a response that arrives while decode is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_instr <= 32'h0000_0000;
            r_hold_pc    <= 32'h0000_0000;
            r_hold_pc4   <= 32'h0000_0000;
        end else if (w_hold_cap) begin
            r_hold_instr <= imem_rdata;
            r_hold_pc    <= r_pcf;
            r_hold_pc4   <= w_pcplus4;
        end
    end

    // IF/ID register: flush beats stall beats load; otherwise insert a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_d <= NOP_INSTR;
            r_pc_d    <= 32'h0000_0000;
            r_pc4_d   <= 32'h0000_0000;
            r_valid_d <= 1'b0;
        end else if (FlushD || PCSrcE) begin
            r_instr_d <= NOP_INSTR;
            r_pc_d    <= 32'h0000_0000;
            r_pc4_d   <= 32'h0000_0000;
            r_valid_d <= 1'b0;
        end else if (StallD) begin
            r_valid_d <= r_valid_d;
        end else if (w_load_mem) begin
            r_instr_d <= imem_rdata;
            r_pc_d    <= r_pcf;
            r_pc4_d   <= w_pcplus4;
            r_valid_d <= 1'b1;
        end else if (w_load_hold) begin
            r_instr_d <= r_hold_instr;
            r_pc_d    <= r_hold_pc;
            r_pc4_d   <= r_hold_pc4;
            r_valid_d <= 1'b1;
        end else begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, reset-mid-transaction sequence,
// and a randomized run against a program-order reference model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF_bar;
    logic        PCSrcE;
    logic        StallD;
    logic        FlushD;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [31:0] tb_target;

    int n_checks = 0;
    int n_fail   = 0;

    // PC-select mux lives outside the stage
    assign PCF_bar = PCSrcE ? tb_target : PCPlus4F;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .PCF_bar(PCF_bar), .PCSrcE(PCSrcE),
        .StallD(StallD), .FlushD(FlushD), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    typedef struct {
        logic [4:0]  ctl;      // {gnt, rvalid, pcsrc, stall, flush}
        logic [31:0] rdata;
        logic [31:0] tgt;
        logic [31:0] e_pcf;
        logic [2:0]  e_flags;  // {req, valid, check PCD/PCPlus4D}
        logic [31:0] e_instr;
        logic [31:0] e_pcd;
        logic [31:0] e_p4;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [4:0] ctl, input logic [31:0] rdata,
                               input logic [31:0] tgt, input logic [31:0] e_pcf,
                               input logic [2:0] e_flags, input logic [31:0] e_instr,
                               input logic [31:0] e_pcd, input logic [31:0] e_p4);
        vec_t r;
        r.ctl = ctl; r.rdata = rdata; r.tgt = tgt; r.e_pcf = e_pcf;
        r.e_flags = e_flags; r.e_instr = e_instr; r.e_pcd = e_pcd; r.e_p4 = e_p4;
        return r;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check32(input string name, input int idx, input logic [31:0] act,
                           input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check1(input string name, input int idx, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0000_0000;
        PCSrcE = 1'b0; StallD = 1'b0; FlushD = 1'b0; tb_target = 32'h0000_0000;
    endtask

    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic        prev_req;
    logic [31:0] prev_addr;
    logic [31:0] exp_next;
    logic [31:0] sv_instr, sv_pcd, sv_p4;
    logic        sv_valid;
    int          deliveries;

    initial begin
        drive_idle();
        rst_n = 1'b0;
        // ---- directed table ----
        vecs.push_back(v(5'b10000, 32'h0,         32'h0,         32'h0000_0100, 3'b001, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b01000, 32'hAAAA_0001, 32'h0,         32'h0000_0104, 3'b111, 32'hAAAA_0001, 32'h0000_0100, 32'h0000_0104));
        vecs.push_back(v(5'b10000, 32'h0,         32'h0,         32'h0000_0104, 3'b000, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b01000, 32'hBBBB_0002, 32'h0,         32'h0000_0108, 3'b111, 32'hBBBB_0002, 32'h0000_0104, 32'h0000_0108));
        vecs.push_back(v(5'b10000, 32'h0,         32'h0,         32'h0000_0108, 3'b000, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b01000, 32'hCCCC_0003, 32'h0,         32'h0000_010C, 3'b111, 32'hCCCC_0003, 32'h0000_0108, 32'h0000_010C));
        vecs.push_back(v(5'b00100, 32'h0,         32'h0000_01FC, 32'h0000_01FC, 3'b101, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b10000, 32'h0,         32'h0,         32'h0000_01FC, 3'b000, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b01000, 32'hDDDD_0004, 32'h0,         32'h0000_0200, 3'b111, 32'hDDDD_0004, 32'h0000_01FC, 32'h0000_0200));
        vecs.push_back(v(5'b10010, 32'h0,         32'h0,         32'h0000_0200, 3'b011, 32'hDDDD_0004, 32'h0000_01FC, 32'h0000_0200));
        vecs.push_back(v(5'b01010, 32'h1234_5678, 32'h0,         32'h0000_0200, 3'b011, 32'hDDDD_0004, 32'h0000_01FC, 32'h0000_0200));
        vecs.push_back(v(5'b00010, 32'h0,         32'h0,         32'h0000_0200, 3'b011, 32'hDDDD_0004, 32'h0000_01FC, 32'h0000_0200));
        vecs.push_back(v(5'b00010, 32'h0,         32'h0,         32'h0000_0200, 3'b011, 32'hDDDD_0004, 32'h0000_01FC, 32'h0000_0200));
        vecs.push_back(v(5'b00000, 32'h0,         32'h0,         32'h0000_0204, 3'b111, 32'h1234_5678, 32'h0000_0200, 32'h0000_0204));
        vecs.push_back(v(5'b10000, 32'h0,         32'h0,         32'h0000_0204, 3'b000, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b00100, 32'h0,         32'h0000_0400, 32'h0000_0400, 3'b001, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b01000, 32'hEEEE_0005, 32'h0,         32'h0000_0400, 3'b100, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b10000, 32'h0,         32'h0,         32'h0000_0400, 3'b000, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b01000, 32'h4444_0000, 32'h0,         32'h0000_0404, 3'b111, 32'h4444_0000, 32'h0000_0400, 32'h0000_0404));
        vecs.push_back(v(5'b10100, 32'h0,         32'h0000_0802, 32'h0000_0800, 3'b001, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b00000, 32'h0,         32'h0,         32'h0000_0800, 3'b000, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b01000, 32'hBAD0_0000, 32'h0,         32'h0000_0800, 3'b100, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b10000, 32'h0,         32'h0,         32'h0000_0800, 3'b000, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b01000, 32'h8888_0008, 32'h0,         32'h0000_0804, 3'b111, 32'h8888_0008, 32'h0000_0800, 32'h0000_0804));
        vecs.push_back(v(5'b00011, 32'h0,         32'h0,         32'h0000_0804, 3'b101, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b00100, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC, 3'b101, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b10000, 32'h0,         32'h0,         32'hFFFF_FFFC, 3'b000, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b01000, 32'h7777_0007, 32'h0,         32'h0000_0000, 3'b111, 32'h7777_0007, 32'hFFFF_FFFC, 32'h0000_0000));
        vecs.push_back(v(5'b10000, 32'h0,         32'h0,         32'h0000_0000, 3'b000, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b01010, 32'h9999_0009, 32'h0,         32'h0000_0000, 3'b000, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b00110, 32'h0,         32'h0000_0042, 32'h0000_0040, 3'b101, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b10000, 32'h0,         32'h0,         32'h0000_0040, 3'b000, NOP,           32'h0,         32'h0));
        vecs.push_back(v(5'b01000, 32'h4040_4040, 32'h0,         32'h0000_0044, 3'b111, 32'h4040_4040, 32'h0000_0040, 32'h0000_0044));
        vecs.push_back(v(5'b01000, 32'hDEAD_BEEF, 32'h0,         32'h0000_0044, 3'b100, NOP,           32'h0,         32'h0));

        #12;
        check32("rst_pcf", 0, PCF, RST_PC);
        check1("rst_req", 0, imem_req, 1'b1);
        check32("rst_instr", 0, InstrD, NOP);
        check32("rst_pcd", 0, PCD, 32'h0);
        check32("rst_pc4d", 0, PCPlus4D, 32'h0);
        check1("rst_valid", 0, ValidD, 1'b0);
        check32("rst_pcplus4f", 0, PCPlus4F, RST_PC + 32'd4);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            {imem_gnt, imem_rvalid, PCSrcE, StallD, FlushD} = vecs[i].ctl;
            imem_rdata = vecs[i].rdata;
            tb_target  = vecs[i].tgt;
            @(negedge clk);
            check32("tbl_pcf", i, PCF, vecs[i].e_pcf);
            check32("tbl_addr", i, imem_addr, vecs[i].e_pcf);
            check32("tbl_pcplus4f", i, PCPlus4F, vecs[i].e_pcf + 32'd4);
            check1("tbl_req", i, imem_req, vecs[i].e_flags[2]);
            check1("tbl_valid", i, ValidD, vecs[i].e_flags[1]);
            check32("tbl_instr", i, InstrD, vecs[i].e_instr);
            if (vecs[i].e_flags[0]) begin
                check32("tbl_pcd", i, PCD, vecs[i].e_pcd);
                check32("tbl_pc4d", i, PCPlus4D, vecs[i].e_p4);
            end
        end

        // ---- reset asserted while a request is outstanding ----
        drive_idle();
        imem_gnt = 1'b1;
        @(negedge clk);
        check1("mid_wait_req", 0, imem_req, 1'b0);
        imem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check32("async_rst_pcf", 0, PCF, RST_PC);
        check1("async_rst_req", 0, imem_req, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0000;
        @(negedge clk);
        check32("stale_pcf", 0, PCF, RST_PC);
        check1("stale_req", 0, imem_req, 1'b1);
        check1("stale_valid", 0, ValidD, 1'b0);
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        check1("post_rst_valid", 0, ValidD, 1'b1);
        check32("post_rst_instr", 0, InstrD, 32'h5555_AAAA);
        check32("post_rst_pcd", 0, PCD, RST_PC);
        check32("post_rst_pcf", 0, PCF, RST_PC + 32'd4);

        // ---- randomized run against a program-order model ----
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
        prev_req = 1'b0; prev_addr = 32'h0;
        exp_next = RST_PC; deliveries = 0;
        sv_instr = NOP; sv_pcd = 32'h0; sv_p4 = 32'h0; sv_valid = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            // memory bookkeeping for the edge just taken
            if (imem_rvalid) mem_pend = 1'b0;
            else if (mem_pend && mem_cnt > 0) mem_cnt--;
            if (prev_req && imem_gnt) begin
                mem_pend = 1'b1; mem_addr = prev_addr; mem_cnt = $urandom_range(0, 2);
            end
            // program-order model: redirect restarts the stream, each delivery advances it
            if (PCSrcE) begin
                exp_next = tb_target & 32'hFFFF_FFFC;
                check1("rnd_redirect_valid", cyc, ValidD, 1'b0);
            end else if (StallD && !FlushD) begin
                check1("rnd_stall_valid", cyc, ValidD, sv_valid);
                check32("rnd_stall_instr", cyc, InstrD, sv_instr);
                check32("rnd_stall_pcd", cyc, PCD, sv_pcd);
                check32("rnd_stall_pc4d", cyc, PCPlus4D, sv_p4);
            end else if (ValidD) begin
                check32("rnd_deliv_pcd", cyc, PCD, exp_next);
                check32("rnd_deliv_instr", cyc, InstrD, mem_word(exp_next));
                check32("rnd_deliv_pc4d", cyc, PCPlus4D, exp_next + 32'd4);
                exp_next = exp_next + 32'd4;
                deliveries++;
            end
            if (FlushD) check1("rnd_flush_valid", cyc, ValidD, 1'b0);
            if (!ValidD) check32("rnd_bubble_instr", cyc, InstrD, NOP);
            check32("rnd_pcf", cyc, PCF, exp_next);
            check32("rnd_addr", cyc, imem_addr, exp_next);
            check32("rnd_pcplus4f", cyc, PCPlus4F, exp_next + 32'd4);
            check1("rnd_req_while_pending", cyc, imem_req & mem_pend, 1'b0);
            sv_instr = InstrD; sv_pcd = PCD; sv_p4 = PCPlus4D; sv_valid = ValidD;
            // drive the next cycle
            prev_req    = imem_req;
            prev_addr   = imem_addr;
            imem_gnt    = imem_req ? ($urandom_range(0, 3) != 0) : 1'b0;
            imem_rvalid = mem_pend && (mem_cnt == 0);
            imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
            PCSrcE      = ($urandom_range(0, 15) == 0);
            tb_target   = $urandom_range(0, 32'h0000_FFFF);
            StallD      = ($urandom_range(0, 2) == 0);
            FlushD      = (StallD || PCSrcE) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        check1("rnd_progress", deliveries, (deliveries > 100), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
